// File: rtl/gpi_status_multi.sv
// gpi_status_multi: per-channel presence qualification with one-slot event queue and valid/ready event port
module gpi_status_multi #(
  parameter int N_CH = 4,
  parameter int HOLD_CYCLES = 4000,
  parameter int RELEASE_CYCLES = 400,
  parameter int SYNC_STAGES = 2,
  localparam int MAX_C = HOLD_CYCLES > RELEASE_CYCLES ? HOLD_CYCLES : RELEASE_CYCLES,
  localparam int CNT_W = $clog2(MAX_C) > 1 ? $clog2(MAX_C) : 1,
  localparam int CH_W = $clog2(N_CH) > 1 ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] fx3_ready,
  input  logic [N_CH-1:0] gpi_status,
  output logic [N_CH-1:0] connected,
  output logic [N_CH-1:0] value,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_type,
  output logic            evt_value,
  output logic [N_CH-1:0] overrun,
  input  logic            overrun_clr
);
  typedef enum logic [1:0] {IDLE, QUALIFY, CONN, REL} state_t;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_MAX = CNT_W'(RELEASE_CYCLES - 1);
  logic [N_CH-1:0] fs [SYNC_STAGES];
  logic [N_CH-1:0] gs [SYNC_STAGES];
  logic [N_CH-1:0] s, g, post, ptype, pval, pend, typ, val, take, ovr_set;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] cnt_n [N_CH];
  state_t st [N_CH];
  state_t st_n [N_CH];
  logic [CH_W-1:0] sel;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        fs[k] <= '0;
        gs[k] <= '0;
      end
    end else begin
      fs[0] <= fx3_ready;
      gs[0] <= gpi_status;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        fs[k] <= fs[k-1];
        gs[k] <= gs[k-1];
      end
    end
  assign s = fs[SYNC_STAGES-1];
  assign g = gs[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      st <= st_n;
      cnt <= cnt_n;
    end
  // Compare precedes increment, so the counter saturates at the terminal value and never wraps.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = cnt[i];
      post[i] = 1'b0;
      ptype[i] = 1'b0;
      case (st[i])
        IDLE: if (s[i]) begin
          st_n[i] = QUALIFY;
          cnt_n[i] = '0;
        end
        QUALIFY:
          if (!s[i]) st_n[i] = IDLE;
          else if (cnt[i] == HOLD_MAX) begin
            st_n[i] = CONN;
            post[i] = 1'b1;
            ptype[i] = 1'b1;
          end else cnt_n[i] = cnt[i] + 1'b1;
        CONN: if (!s[i]) begin
          st_n[i] = REL;
          cnt_n[i] = '0;
        end
        default:
          if (s[i]) st_n[i] = CONN;
          else if (cnt[i] == REL_MAX) begin
            st_n[i] = IDLE;
            post[i] = 1'b1;
          end else cnt_n[i] = cnt[i] + 1'b1;
      endcase
      connected[i] = st[i] == CONN || st[i] == REL;
    end
  end
  assign pval = (ptype & g) | (~ptype & value);
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pend[i]) sel = CH_W'(i);
  end
  assign evt_valid = |pend;
  assign evt_ch = evt_valid ? sel : '0;
  assign evt_type = evt_valid & typ[sel];
  assign evt_value = evt_valid & val[sel];
  assign take = {N_CH{evt_valid & evt_ready}} & (N_CH'(1) << sel);
  assign ovr_set = post & pend & ~take;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend <= '0;
      typ <= '0;
      val <= '0;
      value <= '0;
      overrun <= '0;
    end else begin
      pend <= post | (pend & ~take);
      typ <= (post & ptype) | (~post & typ);
      val <= (post & pval) | (~post & val);
      value <= (post & ptype & g) | (~(post & ptype) & value);
      overrun <= (overrun & ~{N_CH{overrun_clr}}) | ovr_set;
    end
endmodule
